// File: rtl/sig_halt_periph.sv
// sig_halt_periph: AXI4-Lite signature FIFO and sticky halt request for a bench writer.
// Parameters: AXI_AWIDTH, AXI_DWIDTH, BASE_ADDR, FIFO_DEPTH (power of 2), HALT_MAGIC.
// Ports: AXI_ACLK/AXI_ARESETN (async active-low), AXI4-Lite slave AW/W/B/AR/R channels,
//        SIG_TDATA/TVALID/TREADY signature stream, HALT (sticky), DONE (halt and FIFO empty).
// Macro SIG_READBACK_EN: enables register readback; otherwise every read returns 0/SLVERR.
// Map (offset): 0x0 HALT (W magic, R {31'b0,halt}); 0x4 SIG (W push);
//               0x8 STATUS (R {count[15:0],12'b0,full,empty,done,halt}).
module sig_halt_periph #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'hF0000000,
  parameter int FIFO_DEPTH = 8,
  parameter logic [31:0] HALT_MAGIC = 32'hCAFECAFE
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic [AXI_AWIDTH-1:0] AXI_AWADDR,
  input  logic                  AXI_AWVALID,
  output logic                  AXI_AWREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_WDATA,
  input  logic [3:0]            AXI_WSTRB,
  input  logic                  AXI_WVALID,
  output logic                  AXI_WREADY,
  output logic [1:0]            AXI_BRESP,
  output logic                  AXI_BVALID,
  input  logic                  AXI_BREADY,
  input  logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  input  logic                  AXI_ARVALID,
  output logic                  AXI_ARREADY,
  output logic [AXI_DWIDTH-1:0] AXI_RDATA,
  output logic [1:0]            AXI_RRESP,
  output logic                  AXI_RVALID,
  input  logic                  AXI_RREADY,
  output logic [31:0]           SIG_TDATA,
  output logic                  SIG_TVALID,
  input  logic                  SIG_TREADY,
  output logic                  HALT,
  output logic                  DONE
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AXI_AWIDTH-1:0] LP_BASE = AXI_AWIDTH'(BASE_ADDR);
  typedef enum logic [2:0] {W_IDLE, W_AWAIT_DATA, W_AWAIT_ADDR, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_state, w_state_n;
  r_state_t r_rstate, w_rstate_n;
  logic                  r_live;
  logic [AXI_AWIDTH-1:0] r_awaddr;
  logic [AXI_DWIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_halt, r_done;
  logic [AXI_DWIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic [31:0]           r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_count, w_count_n;
  logic w_aw_hs, w_w_hs, w_ar_hs, w_aw_halt, w_aw_sig, w_full, w_empty, w_pop, w_push;
  logic w_stall, w_exec_done, w_halt_set, w_halt_n;
  logic [31:0]           w_sig_data;
  logic [AXI_DWIDTH-1:0] w_rdata;
  logic [1:0]            w_rresp;
  // Holding registers are implied by the state: AW is held in AWAIT_DATA/EXEC, W in AWAIT_ADDR/EXEC.
  // r_live keeps the readies low until the first clock edge after reset release.
  assign AXI_AWREADY = r_live && (r_state == W_IDLE || r_state == W_AWAIT_ADDR);
  assign AXI_WREADY  = r_live && (r_state == W_IDLE || r_state == W_AWAIT_DATA);
  assign AXI_ARREADY = r_live && r_rstate == R_IDLE;
  assign AXI_BVALID  = r_bvalid;
  assign AXI_BRESP   = r_bresp;
  assign AXI_RVALID  = r_rstate == R_DATA;
  assign AXI_RDATA   = r_rdata;
  assign AXI_RRESP   = r_rresp;
  assign HALT        = r_halt;
  assign DONE        = r_done;
  assign w_aw_hs     = AXI_AWVALID && AXI_AWREADY;
  assign w_w_hs      = AXI_WVALID && AXI_WREADY;
  assign w_ar_hs     = AXI_ARVALID && AXI_ARREADY;
  assign w_aw_halt   = r_awaddr == LP_BASE;
  assign w_aw_sig    = r_awaddr == LP_BASE + AXI_AWIDTH'(4);
  assign w_empty     = r_count == '0;
  assign w_full      = r_count == (PW+1)'(FIFO_DEPTH);
  assign SIG_TVALID  = !w_empty;
  assign SIG_TDATA   = w_empty ? 32'h0 : r_mem[r_rptr];
  assign w_pop       = SIG_TVALID && SIG_TREADY;
  // A pop in the same cycle frees the slot, so a full FIFO need not stall.
  assign w_stall     = w_aw_sig && w_full && !w_pop;
  assign w_exec_done = r_state == W_EXEC && !w_stall;
  assign w_push      = w_exec_done && w_aw_sig;
  assign w_halt_set  = w_exec_done && w_aw_halt && r_wdata[31:0] == HALT_MAGIC && r_wstrb == 4'hF;
  assign w_halt_n    = r_halt || w_halt_set;
  assign w_count_n   = r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
  assign w_sig_data  = r_wdata[31:0] & {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      W_IDLE:       w_state_n = (w_aw_hs && w_w_hs) ? W_EXEC : w_aw_hs ? W_AWAIT_DATA : w_w_hs ? W_AWAIT_ADDR : W_IDLE;
      W_AWAIT_DATA: w_state_n = w_w_hs ? W_EXEC : W_AWAIT_DATA;
      W_AWAIT_ADDR: w_state_n = w_aw_hs ? W_EXEC : W_AWAIT_ADDR;
      W_EXEC:       w_state_n = w_stall ? W_EXEC : W_RESP;
      W_RESP:       w_state_n = (r_bvalid && AXI_BREADY) ? W_IDLE : W_RESP;
      default:      w_state_n = W_IDLE;
    endcase
  end
  always_comb begin
    w_rstate_n = r_rstate;
    if (r_rstate == R_IDLE && w_ar_hs) w_rstate_n = R_DATA;
    else if (r_rstate == R_DATA && AXI_RREADY) w_rstate_n = R_IDLE;
  end
`ifdef SIG_READBACK_EN
  always_comb begin
    w_rdata = '0;
    w_rresp = 2'b10;
    if (AXI_ARADDR == LP_BASE) begin
      w_rdata = AXI_DWIDTH'({31'b0, r_halt});
      w_rresp = 2'b00;
    end else if (AXI_ARADDR == LP_BASE + AXI_AWIDTH'(8)) begin
      w_rdata = AXI_DWIDTH'({16'(r_count), 12'b0, w_full, w_empty, r_done, r_halt});
      w_rresp = 2'b00;
    end
  end
`else
  assign w_rdata = '0;
  assign w_rresp = 2'b10;
`endif
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_state  <= W_IDLE;
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
      r_awaddr <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
      r_halt   <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_rstate <= w_rstate_n;
      r_live   <= 1'b1;
      if (w_aw_hs) r_awaddr <= AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= AXI_WDATA;
        r_wstrb <= AXI_WSTRB;
      end
      // BVALID follows one cycle after EXEC retires into RESP.
      r_bvalid <= r_state == W_RESP && !(r_bvalid && AXI_BREADY);
      if (w_exec_done) r_bresp <= (w_aw_halt || w_aw_sig) ? 2'b00 : 2'b10;
      r_halt   <= w_halt_n;
      r_done   <= w_halt_n && w_count_n == '0;
      if (w_ar_hs) begin
        r_rdata <= w_rdata;
        r_rresp <= w_rresp;
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count  <= w_count_n;
    end
  end
  always_ff @(posedge AXI_ACLK) begin
    if (w_push) r_mem[r_wptr] <= w_sig_data;
  end
endmodule

// File: doc/sig_halt_periph.md
SIG_HALT_PERIPH -- requirements
Module: sig_halt_periph

Interface
REQ-001 SHALL have parameter AXI_AWIDTH, default 32, the AXI address width.
REQ-002 SHALL have parameter AXI_DWIDTH, default 32, the AXI data width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'hF0000000, the register block base address.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, the signature FIFO entry count (power of 2, ≥2).
REQ-005 SHALL have parameter HALT_MAGIC, default 32'hCAFECAFE, the halt trigger value.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  reset
REQ-007 SHALL provide the AXI4-Lite slave write ports, from the core HOST_AXI_* bus:
- AXI_AWADDR/AWVALID/AWREADY  in/in/out  AXI_AWIDTH/1/1  write address
- AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  AXI_DWIDTH/4/1/1  write data
- AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response
REQ-008 SHALL provide the AXI4-Lite slave read ports:
- AXI_ARADDR/ARVALID/ARREADY  in/in/out  AXI_AWIDTH/1/1  read address
- AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  AXI_DWIDTH/2/1/1  read data
REQ-009 SHALL provide these output ports:
- SIG_TDATA/SIG_TVALID/SIG_TREADY  out/out/in  32/1/1  signature stream to the bench writer
- HALT  out  1  sticky halt request
- DONE  out  1  HALT and FIFO empty

Function
REQ-010 The register map, as an offset from BASE_ADDR, SHALL be: 0x0 HALT (W: magic; R: {31'b0,halt}), 0x4 SIG (W: push), 0x8 STATUS (R: {count[15:0],12'b0,full,empty,done,halt}).
REQ-011 AW and W SHALL be accepted independently: each ready is high while its holding register is empty and no response is pending; the accepted beat is latched.
REQ-012 The write FSM SHALL use states W_IDLE (both empty) → W_AWAIT_DATA | W_AWAIT_ADDR (one held) → W_EXEC (both held) → W_RESP (BVALID=1 until BREADY) → W_IDLE.
REQ-013 In W_EXEC, a SIG write with the FIFO full SHALL stall in W_EXEC; a simultaneous SIG_TREADY pop SHALL permit the push in that same cycle.
REQ-014 On a SIG push, bytes with WSTRB low SHALL be stored as 0x00.
REQ-015 On a HALT write with WDATA==HALT_MAGIC and WSTRB==4'hF, halt SHALL be set (sticky); other data SHALL be ignored with BRESP OKAY.
REQ-016 A write to an address outside BASE_ADDR+{0x0,0x4}, including 0x8, SHALL give BRESP=2'b10 (SLVERR) with no side effect.
REQ-017 BVALID SHALL rise exactly one cycle after W_EXEC completes; minimum AW/W handshake to BVALID latency is 2 cycles.
REQ-018 The FIFO SHALL be first-word-fall-through: SIG_TVALID=!empty, SIG_TDATA=head, pop on SIG_TVALID&&SIG_TREADY; pointers SHALL wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
REQ-019 HALT SHALL be registered; DONE=halt&&empty, registered, so it deasserts if a push follows halt.
REQ-020 Signature writes after halt SHALL still be accepted.

Reset
REQ-021 Assertion of AXI_ARESETN low, at any time including mid-transaction, SHALL drive AWREADY, WREADY, BVALID, ARREADY, RVALID, SIG_TVALID, HALT, DONE to 0, BRESP/RRESP/RDATA to 0, empty the FIFO, clear holding registers, and return both FSMs to idle.
REQ-022 The readies SHALL first assert on the first AXI_ACLK edge after reset deassertion.

Configuration
REQ-023 With macro SIG_READBACK_EN defined, reads SHALL follow REQ-010: ARREADY high in R_IDLE; AR handshake → R_DATA next cycle with RVALID=1 held until RREADY; unmapped offsets SHALL return RDATA=0, RRESP=SLVERR.
REQ-024 Without SIG_READBACK_EN, every AR SHALL be accepted and answered one cycle later with RDATA=0, RRESP=2'b10; no status logic is synthesized.

Verification
REQ-025 Write 0xDEADBEEF to 0xF0000004, SIG_TREADY=1 → BRESP OKAY 2 cycles after handshake; SIG_TDATA=0xDEADBEEF for one beat.
REQ-026 SIG_TREADY=0, 9 SIG writes with FIFO_DEPTH=8 → 9th write stalls without BVALID; one pop → 9th completes, and entries pop in order 1..9.
REQ-027 Write 0x12345678 then 0xCAFECAFE to 0xF0000000 → HALT stays 0 after the first and is 1 after the second; DONE=1 once the FIFO is empty.
REQ-028 W is presented 3 cycles before AW to 0xF0000010 → BRESP=SLVERR, FIFO unchanged, halt unchanged.
REQ-029 AXI_ARESETN is pulsed low with 3 FIFO entries and BVALID pending → all outputs are 0 and the FIFO is empty; the next write completes normally.
REQ-030 (SIG_READBACK_EN) With 2 entries and halt set, read 0x8 → RDATA=0x0002_0001; without the macro → RDATA=0, RRESP=SLVERR.
